// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if: pipeline-side bus of the CP0 exception unit.
// master (pipeline/bench) drives MEM-stage info, interrupt pins and MTC0/MFC0 access;
// slave (cp0_exc_unit) returns read data, the exception decision and Status/Cause/EPC.
interface cp0_exc_unit_if;
  logic [5:0]  ext_int;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_inslot;
  logic [9:0]  mem_excreq;
  logic [31:0] mem_addr;
  logic        cp0_wen;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_flag;
  logic [4:0]  exc_type;
  logic [31:0] cp0_Status;
  logic [31:0] cp0_Cause;
  logic [31:0] cp0_EPC;
  modport master(
    output ext_int, mem_valid, mem_pc, mem_inslot, mem_excreq, mem_addr, cp0_wen, cp0_addr, cp0_wdata,
    input  cp0_rdata, exc_flag, exc_type, cp0_Status, cp0_Cause, cp0_EPC
  );
  modport slave(
    input  ext_int, mem_valid, mem_pc, mem_inslot, mem_excreq, mem_addr, cp0_wen, cp0_addr, cp0_wdata,
    output cp0_rdata, exc_flag, exc_type, cp0_Status, cp0_Cause, cp0_EPC
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 register file with exception prioritisation, commit and Count/Compare timer.
// Ports: clk, resetn (async active-low), bus (cp0_exc_unit_if.slave): MEM-stage requests,
// interrupt pins and MTC0 in; exc_flag/exc_type, MFC0 data and Status/Cause/EPC out.
module cp0_exc_unit #(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter int          TIMER_DIV = 2
) (
  input logic           clk,
  input logic           resetn,
  cp0_exc_unit_if.slave bus
);
  localparam int TW = TIMER_DIV > 1 ? $clog2(TIMER_DIV) : 1;
  logic          bev, exl, ie, bd, ti, iv;
  logic [7:0]    im, ip;
  logic [4:0]    exccode;
  logic [31:0]   epc, badvaddr, count, compare, count_nxt, status, cause;
  logic [TW-1:0] tick;
  logic [5:0]    sync;
  logic [9:0]    req;
  logic          int_req, eret, wr, wr_cnt, wr_cmp, tick_wrap, count_upd;
  assign req       = bus.mem_valid ? bus.mem_excreq : '0;
  assign int_req   = ie & ~exl & |(ip & im) & bus.mem_valid;
  assign bus.exc_flag = int_req | |req;
  // ERET is lowest priority, so it only commits when it is the sole request
  assign eret      = ~int_req & (req == 10'h200);
  assign wr        = bus.cp0_wen & ~bus.exc_flag;
  assign wr_cnt    = wr & (bus.cp0_addr == 5'd9);
  assign wr_cmp    = wr & (bus.cp0_addr == 5'd11);
  assign tick_wrap = tick == TW'(TIMER_DIV - 1);
  assign count_upd = tick_wrap | wr_cnt;
  assign count_nxt = wr_cnt ? bus.cp0_wdata : count + 32'(tick_wrap);
  assign status    = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
  assign cause     = {bd, ti, 6'b0, iv, 7'b0, ip, 1'b0, exccode, 2'b0};
  assign bus.cp0_Status = status;
  assign bus.cp0_Cause  = cause;
  assign bus.cp0_EPC    = epc;
  assign bus.exc_type =
    (!bus.exc_flag || int_req) ? 5'h00 :
    req[0] ? 5'h04 : req[1] ? 5'h0A : req[2] ? 5'h0B : req[3] ? 5'h0C : req[4] ? 5'h0D :
    req[5] ? 5'h08 : req[6] ? 5'h09 : req[7] ? 5'h04 : req[8] ? 5'h05 : 5'h1F;
  assign bus.cp0_rdata =
    bus.cp0_addr == 5'd8  ? badvaddr :
    bus.cp0_addr == 5'd9  ? count    :
    bus.cp0_addr == 5'd11 ? compare  :
    bus.cp0_addr == 5'd12 ? status   :
    bus.cp0_addr == 5'd13 ? cause    :
    bus.cp0_addr == 5'd14 ? epc      :
    bus.cp0_addr == 5'd15 ? PRID     : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      {bev, im, exl, ie} <= {1'b1, 8'h00, 1'b0, 1'b0};
      {bd, ti, iv, ip, exccode} <= '0;
      epc      <= '0;
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      tick     <= '0;
      sync     <= '0;
    end else begin
      // sync is the first synchroniser stage; IP[7:2] itself is the second
      sync    <= bus.ext_int;
      ip[7:2] <= {sync[5] | ti, sync[4:0]};
      tick    <= (tick_wrap | wr_cnt) ? '0 : tick + 1'b1;
      count   <= count_nxt;
      ti      <= wr_cmp ? 1'b0 : ti | (count_upd & (count_nxt == compare));
      if (wr_cmp) compare <= bus.cp0_wdata;
      if (wr && bus.cp0_addr == 5'd12) {bev, im, exl, ie} <= {bus.cp0_wdata[22], bus.cp0_wdata[15:8], bus.cp0_wdata[1:0]};
      if (wr && bus.cp0_addr == 5'd13) {iv, ip[1:0]} <= {bus.cp0_wdata[23], bus.cp0_wdata[9:8]};
      if (wr && bus.cp0_addr == 5'd14) epc <= bus.cp0_wdata;
      if (bus.exc_flag) begin
        if (eret) exl <= 1'b0;
        else begin
          // nested exceptions keep the original return point
          if (!exl) begin
            epc <= bus.mem_inslot ? bus.mem_pc - 32'd4 : bus.mem_pc;
            bd  <= bus.mem_inslot;
          end
          exl     <= 1'b1;
          exccode <= bus.exc_type;
          if (!int_req && req[0]) badvaddr <= bus.mem_pc;
          else if (!int_req && req[6:0] == '0 && |req[8:7]) badvaddr <= bus.mem_addr;
        end
      end
    end
  end
endmodule
